// File: rtl/drac_pkg.sv
// Shared state encodings and default parameters for the core reset sequencer.
package drac_pkg;

  typedef enum logic [1:0] {G_HOLD, G_WAKE, G_STAGGER, G_RUN} glb_state_e;
  typedef enum logic [1:0] {S_IDLE, S_QUIESCE, S_HOLDRST} srst_state_e;

  localparam int DefNumHarts       = 4;
  localparam int DefWakeUpCycles   = 32768;
  localparam int DefStaggerCycles  = 16;
  localparam int DefSoftRstCycles  = 64;
  localparam int DefQuiesceTimeout = 1024;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hart_soft_rst_fsm.sv
// Soft-reset servicing: drains one pending hart at a time (lowest index first),
// then holds its reset for a fixed window. One counter serves both waits.
module hart_soft_rst_fsm
  import drac_pkg::*;
#(
  parameter int NumHarts       = DefNumHarts,
  parameter int SoftRstCycles  = DefSoftRstCycles,
  parameter int QuiesceTimeout = DefQuiesceTimeout
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                run_i,
  input  logic [NumHarts-1:0] pending_i,
  input  logic [NumHarts-1:0] ack_i,
  output logic [NumHarts-1:0] quiesce_req_o,
  output logic [NumHarts-1:0] hold_o,
  output logic [NumHarts-1:0] active_o,
  output logic [NumHarts-1:0] done_o,
  output logic                busy_o,
  output logic                timeout_o
);

  localparam int CW = $clog2(max2(SoftRstCycles, QuiesceTimeout) + 1);

  srst_state_e         st_q, st_d;
  logic [NumHarts-1:0] cur_q, cur_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                tmo_q, tmo_d;
  logic                hold_end;

  assign hold_end      = (st_q == S_HOLDRST) && (cnt_q == CW'(SoftRstCycles - 1));
  assign quiesce_req_o = (st_q == S_QUIESCE) ? cur_q : '0;
  assign hold_o        = (st_q == S_HOLDRST) ? cur_q : '0;
  assign active_o      = (st_q != S_IDLE)    ? cur_q : '0;
  assign done_o        = hold_end ? cur_q : '0;
  assign busy_o        = (st_q != S_IDLE);
  assign timeout_o     = tmo_q;

  always_comb begin
    st_d  = st_q;
    cur_d = cur_q;
    cnt_d = cnt_q;
    tmo_d = 1'b0;
    case (st_q)
      S_IDLE: if (run_i && (|pending_i)) begin
        // isolate the lowest set bit: the hart to service next
        cur_d = pending_i & (~pending_i + NumHarts'(1));
        cnt_d = '0;
        st_d  = S_QUIESCE;
      end
      S_QUIESCE: begin
        // an acknowledge in the final wait cycle beats the timeout
        if (|(ack_i & cur_q)) begin
          cnt_d = '0;
          st_d  = S_HOLDRST;
        end else if (cnt_q == CW'(QuiesceTimeout - 1)) begin
          cnt_d = '0;
          tmo_d = 1'b1;
          st_d  = S_HOLDRST;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLDRST: begin
        if (hold_end) begin
          cur_d = '0;
          st_d  = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q  <= S_IDLE;
      cur_q <= '0;
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cur_q <= cur_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

endmodule

// File: rtl/core_reset_sequencer.sv
// Boot-time staggered hart reset release plus run-time per-hart soft reset
// with quiesce handshake.
module core_reset_sequencer
  import drac_pkg::*;
#(
  parameter int NumHarts       = DefNumHarts,
  parameter int WakeUpCycles   = DefWakeUpCycles,
  parameter int StaggerCycles  = DefStaggerCycles,
  parameter int SoftRstCycles  = DefSoftRstCycles,
  parameter int QuiesceTimeout = DefQuiesceTimeout
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumHarts-1:0] soft_rst_req_i,
  input  logic [NumHarts-1:0] quiesce_ack_i,
  output logic [NumHarts-1:0] hart_rstn_o,
  output logic [NumHarts-1:0] quiesce_req_o,
  output logic                grst_l_o,
  output logic                all_running_o,
  output logic                timeout_o
);

  localparam int WCW = $clog2(WakeUpCycles + 1);
  localparam int SCW = (StaggerCycles > 0) ? $clog2(StaggerCycles + 1) : 1;
  localparam int IW  = $clog2(NumHarts + 1);

  glb_state_e          state_q, state_d;
  logic [WCW-1:0]      wcnt_q, wcnt_d;
  logic [SCW-1:0]      scnt_q, scnt_d;
  logic [IW-1:0]       nidx_q, nidx_d;
  logic [NumHarts-1:0] boot_rel_q, boot_rel_d;
  logic [NumHarts-1:0] pend_q, pend_d;
  logic [NumHarts-1:0] hold, active, done;
  logic                busy, run;

  assign run           = (state_q == G_RUN);
  assign hart_rstn_o   = boot_rel_q & ~hold;
  assign all_running_o = run & ~busy;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    scnt_d     = scnt_q;
    nidx_d     = nidx_q;
    boot_rel_d = boot_rel_q;
    unique case (state_q)
      G_HOLD: begin
        state_d = G_WAKE;
        wcnt_d  = '0;
      end
      G_WAKE: begin
        if (wcnt_q == WCW'(WakeUpCycles - 1)) begin
          boot_rel_d[0] = 1'b1;
          if (StaggerCycles == 0) begin
            boot_rel_d = '1;
            nidx_d     = IW'(NumHarts);
          end else begin
            nidx_d = IW'(1);
          end
          scnt_d  = '0;
          state_d = G_STAGGER;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      G_STAGGER: begin
        // nidx_q == NumHarts means the last hart went out last cycle
        if (nidx_q == IW'(NumHarts)) begin
          state_d = G_RUN;
        end else if (scnt_q == SCW'(StaggerCycles - 1)) begin
          for (int i = 0; i < NumHarts; i++)
            if (nidx_q == IW'(i)) boot_rel_d[i] = 1'b1;
          nidx_d = nidx_q + 1'b1;
          scnt_d = '0;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      G_RUN: ;
    endcase
  end

  // requests for the hart currently being serviced are dropped
  always_comb begin
    pend_d = pend_q;
    if (state_q != G_HOLD) pend_d = (pend_q & ~done) | (soft_rst_req_i & ~active);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= G_HOLD;
      wcnt_q     <= '0;
      scnt_q     <= '0;
      nidx_q     <= '0;
      boot_rel_q <= '0;
      pend_q     <= '0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      scnt_q     <= scnt_d;
      nidx_q     <= nidx_d;
      boot_rel_q <= boot_rel_d;
      pend_q     <= pend_d;
    end
  end

  always_ff @(posedge clk_i) grst_l_o <= ~rst_i;

  hart_soft_rst_fsm #(
    .NumHarts      (NumHarts),
    .SoftRstCycles (SoftRstCycles),
    .QuiesceTimeout(QuiesceTimeout)
  ) u_srst (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .run_i        (run),
    .pending_i    (pend_q),
    .ack_i        (quiesce_ack_i),
    .quiesce_req_o(quiesce_req_o),
    .hold_o       (hold),
    .active_o     (active),
    .done_o       (done),
    .busy_o       (busy),
    .timeout_o    (timeout_o)
  );

endmodule

// File: tb/tb_core_reset_sequencer.sv
// Self-checking bench: boot table, directed soft-reset sequences and a random
// phase compared every cycle against a timestamp-based reference model.
module tb_core_reset_sequencer;

  localparam int N      = 4;
  localparam int W      = 100;
  localparam int S      = 10;
  localparam int SR     = 8;
  localparam int QT     = 20;
  localparam int RUN_AT = W + (N - 1) * S + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, ack;
  logic [N-1:0] hart_rstn, qreq;
  logic         grst_l, all_running, timeout;

  always #5 clk = ~clk;

  core_reset_sequencer #(
    .NumHarts(N), .WakeUpCycles(W), .StaggerCycles(S),
    .SoftRstCycles(SR), .QuiesceTimeout(QT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .soft_rst_req_i(req), .quiesce_ack_i(ack),
    .hart_rstn_o(hart_rstn), .quiesce_req_o(qreq), .grst_l_o(grst_l),
    .all_running_o(all_running), .timeout_o(timeout)
  );

  int checks = 0;
  int errors = 0;
  int ncyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (tick %0d): got %0h expected %0h", nm, ncyc, act, exp);
    end
  endtask

  // Reference model: cycle number since release plus service timestamps.
  bit           m_valid = 0;
  int           m_cyc = -1;
  logic [N-1:0] m_pend = '0;
  int           m_cur = -1, m_qs = -1, m_hs = -1;
  bit           m_to = 0, m_grst = 0;

  task automatic model_step();
    int           now;
    bit           was_run;
    logic [N-1:0] amask, clr;
    m_grst = !rst;
    m_to   = 0;
    if (rst) begin
      m_valid = 1; m_cyc = -1; m_pend = '0; m_cur = -1; m_qs = -1; m_hs = -1;
      return;
    end
    was_run = (m_cyc >= RUN_AT);
    now     = m_cyc + 1;
    amask   = '0;
    clr     = '0;
    if (m_cur >= 0) amask[m_cur] = 1'b1;
    if (m_cur < 0) begin
      if (was_run && m_pend != '0) begin
        for (int i = N - 1; i >= 0; i--) if (m_pend[i]) m_cur = i;
        m_qs = now; m_hs = -1;
      end
    end else if (m_hs < 0) begin
      if (ack[m_cur]) m_hs = now;
      else if (now - m_qs == QT) begin m_hs = now; m_to = 1; end
    end else if (now - m_hs == SR) begin
      clr[m_cur] = 1'b1; m_cur = -1;
    end
    if (m_cyc >= 0) m_pend = (m_pend & ~clr) | (req & ~amask);
    m_cyc = now;
  endtask

  function automatic logic [N-1:0] e_hart();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = (m_cyc >= W + i * S) && !(m_cur == i && m_hs >= 0);
    return v;
  endfunction

  function automatic logic [N-1:0] e_qreq();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = (m_cur == i && m_hs < 0);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    ncyc++;
    if (m_valid) begin
      chk("m_hart_rstn", 32'(hart_rstn), 32'(e_hart()));
      chk("m_quiesce_req", 32'(qreq), 32'(e_qreq()));
      chk("m_all_running", 32'(all_running), 32'(m_cyc >= RUN_AT && m_cur < 0));
      chk("m_timeout", 32'(timeout), 32'(m_to));
      chk("m_grst_l", 32'(grst_l), 32'(m_grst));
    end
  endtask

  // Boot vectors: cycle relative to first rst_i=0 sample, expected outputs.
  typedef struct {
    int           cyc;
    logic [N-1:0] hart;
    logic         run;
    logic         grst;
  } bvec_t;
  localparam int NB = 12;
  bvec_t btab[NB];

  task automatic boot();
    int ti = 0;
    req = '0; ack = '0;
    for (int c = -5; c <= 140; c++) begin
      rst = (c < 0);
      tick();
      if (ti < NB && btab[ti].cyc == c) begin
        chk($sformatf("boot_hart@%0d", c), 32'(hart_rstn), 32'(btab[ti].hart));
        chk($sformatf("boot_run@%0d", c), 32'(all_running), 32'(btab[ti].run));
        chk($sformatf("boot_grst@%0d", c), 32'(grst_l), 32'(btab[ti].grst));
        ti++;
      end
    end
    rst = 1'b0;
    chk("boot_table_done", ti, NB);
  endtask

  task automatic wait_q(input int h, output bit got);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      got = qreq[h];
    end
    chk($sformatf("q%0d_rise", h), 32'(got), 32'd1);
  endtask

  task automatic seq_ack();
    int lo = 0; bit bad = 0, to = 0, got;
    req = 4'b0100; tick(); req = '0;
    wait_q(2, got);
    tick(); tick();
    ack = 4'b0100;
    for (int k = 0; k < 30; k++) begin
      tick();
      ack = '0;
      if (!hart_rstn[2]) lo++;
      if ((hart_rstn & 4'b1011) != 4'b1011) bad = 1;
      if (timeout) to = 1;
    end
    chk("ack_hold_len", lo, 8);
    chk("ack_others_up", 32'(bad), 0);
    chk("ack_no_timeout", 32'(to), 0);
  endtask

  task automatic seq_timeout();
    int t_q, t_to = -1, pulses = 0, lo = 0; bit got;
    req = 4'b0010; tick(); req = '0;
    wait_q(1, got);
    t_q = ncyc;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (timeout) begin pulses++; if (t_to < 0) t_to = ncyc; end
      if (!hart_rstn[1]) lo++;
    end
    chk("to_delay", t_to - t_q, 20);
    chk("to_pulses", pulses, 1);
    chk("to_hold_len", lo, 8);
  endtask

  task automatic seq_coincide();
    bit got;
    req = 4'b0001; tick(); req = '0;
    wait_q(0, got);
    for (int k = 0; k < 19; k++) tick();
    ack = 4'b0001; tick(); ack = '0;
    chk("co_no_timeout", 32'(timeout), 0);
    chk("co_in_hold", 32'(hart_rstn[0]), 0);
    for (int k = 0; k < 12; k++) tick();
  endtask

  task automatic seq_simul();
    int f0 = -1, l0 = -1, f3 = -1, n0 = 0, n3 = 0;
    req = 4'b1001; tick(); req = '0;
    for (int k = 0; k < 80; k++) begin
      tick();
      ack = qreq;
      if (!hart_rstn[0]) begin n0++; l0 = ncyc; if (f0 < 0) f0 = ncyc; end
      if (!hart_rstn[3]) begin n3++; if (f3 < 0) f3 = ncyc; end
    end
    ack = '0;
    chk("sim_h0_len", n0, 8);
    chk("sim_h3_len", n3, 8);
    chk("sim_h0_first", 32'(f0 >= 0 && f0 < f3), 1);
    chk("sim_no_overlap", 32'(l0 < f3), 1);
  endtask

  task automatic seq_reset_mid();
    bit held = 0, qs = 0, rdrop = 0;
    req = 4'b1000; tick(); req = '0;
    for (int k = 0; k < 20 && !held; k++) begin
      tick();
      ack = qreq;
      held = !hart_rstn[3];
    end
    ack = '0;
    chk("mid_reached_hold", 32'(held), 1);
    tick(); tick();
    rst = 1'b1; tick();
    chk("mid_rst_hart", 32'(hart_rstn), 0);
    chk("mid_rst_qreq", 32'(qreq), 0);
    chk("mid_rst_run", 32'(all_running), 0);
    chk("mid_rst_timeout", 32'(timeout), 0);
    chk("mid_rst_grst", 32'(grst_l), 0);
    boot();
    for (int k = 0; k < 30; k++) begin
      tick();
      if (qreq != '0) qs = 1;
      if (!all_running) rdrop = 1;
    end
    chk("mid_pending_lost", 32'(qs), 0);
    chk("mid_still_running", 32'(rdrop), 0);
  endtask

  initial begin
    btab = '{
      '{-5, 4'b0000, 1'b0, 1'b0}, '{-1, 4'b0000, 1'b0, 1'b0},
      '{0, 4'b0000, 1'b0, 1'b1},  '{99, 4'b0000, 1'b0, 1'b1},
      '{100, 4'b0001, 1'b0, 1'b1}, '{109, 4'b0001, 1'b0, 1'b1},
      '{110, 4'b0011, 1'b0, 1'b1}, '{119, 4'b0011, 1'b0, 1'b1},
      '{120, 4'b0111, 1'b0, 1'b1}, '{129, 4'b0111, 1'b0, 1'b1},
      '{130, 4'b1111, 1'b0, 1'b1}, '{131, 4'b1111, 1'b1, 1'b1}
    };
    rst = 1'b1; req = '0; ack = '0;
    boot();
    seq_ack();
    seq_timeout();
    seq_coincide();
    seq_simul();
    seq_reset_mid();
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 1499) == 0);
      req = ($urandom_range(0, 29) == 0) ? N'($urandom) : '0;
      ack = ((n / 500) % 2 == 1) ? N'($urandom & $urandom) : '0;
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete, tick %0d", ncyc);
    $fatal(1);
  end

endmodule

// File: doc/core_reset_sequencer.md
CORE_RESET_SEQUENCER -- requirements
Module: core_reset_sequencer

Interface
REQ-001 SHALL have parameter NumHarts, default 4: number of hart reset domains, legal range 1..8.
REQ-002 SHALL have parameter WakeUpCycles, default 32768: cycles from reset release to the first hart release, minimum 1.
REQ-003 SHALL have parameter StaggerCycles, default 16: cycles between consecutive hart releases; 0 is legal.
REQ-004 SHALL have parameter SoftRstCycles, default 64: hart reset hold length during a soft reset, minimum 1.
REQ-005 SHALL have parameter QuiesceTimeout, default 1024: maximum cycles to wait for a quiesce acknowledge, minimum 1.
REQ-006 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port soft_rst_req_i, input, NumHarts bits: per-hart soft-reset request pulse.
REQ-009 SHALL have port quiesce_ack_i, input, NumHarts bits: per-hart acknowledge that the hart is idle.
REQ-010 SHALL have port hart_rstn_o, output, NumHarts bits: per-hart reset, active-low.
REQ-011 SHALL have port quiesce_req_o, output, NumHarts bits: per-hart drain request.
REQ-012 SHALL have port grst_l_o, output, 1 bit: ~rst_i registered by one cycle (global reset, active-low).
REQ-013 SHALL have port all_running_o, output, 1 bit: high when all harts are out of reset and no soft reset is active.
REQ-014 SHALL have port timeout_o, output, 1 bit: one-cycle pulse when a quiesce wait times out.

Function
REQ-015 SHALL implement a global FSM with states HOLD, WAKE, STAGGER and RUN.
REQ-016 SHALL stay in HOLD while rst_i=1, then move to WAKE; cycle 0 is defined as the first cycle in which rst_i=0 is sampled.
REQ-017 SHALL raise hart_rstn_o[i] at cycle WakeUpCycles + i*StaggerCycles, in index order, and never drop it again except under REQ-021 or REQ-026.
REQ-018 SHALL release all harts in the same cycle when StaggerCycles=0.
REQ-019 SHALL enter RUN one cycle after the last hart release and assert all_running_o in that same cycle.
REQ-020 SHALL latch soft_rst_req_i bits into a pending vector in every state except HOLD; a request for a hart whose soft reset is already active SHALL be ignored.
REQ-021 SHALL, in RUN only, service pending harts one at a time, lowest index first, through sub-states IDLE -> QUIESCE -> HOLDRST -> IDLE:
- QUIESCE: quiesce_req_o[h]=1.
- On sampling quiesce_ack_i[h]=1: the next cycle drops quiesce_req_o[h] and drives hart_rstn_o[h]=0.
- HOLDRST: hart_rstn_o[h] is held 0 for exactly SoftRstCycles cycles, then returns to 1 and pending[h] is cleared.
REQ-022 SHALL, if no acknowledge arrives within QuiesceTimeout cycles, pulse timeout_o for 1 cycle and proceed to HOLDRST.
REQ-023 SHALL deassert all_running_o whenever the soft-reset sub-state is not IDLE.
REQ-024 SHALL size each counter to $clog2(max parameter + 1) bits and SHALL never let a counter wrap.
REQ-025 SHALL, when an acknowledge and the timeout coincide in the same cycle, treat the acknowledge as winning: no timeout_o pulse.

Reset
REQ-026 SHALL, at the clock edge where rst_i=1 is sampled in any state (including mid-stagger or mid-soft-reset), drive hart_rstn_o='0, quiesce_req_o='0, all_running_o=0 and timeout_o=0, clear the pending vector and all counters, and enter HOLD.
REQ-027 SHALL have grst_l_o=0 in the cycle after rst_i=1 is sampled, with no asynchronous path.

Structure
REQ-028 SHALL place the global and soft-reset state enums and the default parameter constants in drac_pkg.
REQ-029 SHALL implement the soft-reset sub-FSM and its timeout/hold counter as one sub-module, hart_soft_rst_fsm.

Verification
Bench parameters: NumHarts=4, WakeUpCycles=100, StaggerCycles=10, SoftRstCycles=8, QuiesceTimeout=20.
REQ-030 SHALL cover boot: rst_i high for 5 cycles then low -> hart_rstn_o bits rise at cycles 100, 110, 120 and 130; all_running_o rises at cycle 131.
REQ-031 SHALL cover acknowledged soft reset: pulse soft_rst_req_i[2] in RUN, acknowledge after 3 cycles -> hart_rstn_o[2] is low for exactly 8 cycles, the other harts stay at 1, and timeout_o stays 0.
REQ-032 SHALL cover timeout: pulse soft_rst_req_i[1] and never acknowledge -> timeout_o pulses once 20 cycles after quiesce_req_o[1] rises, followed by an 8-cycle hold.
REQ-033 SHALL cover simultaneous requests: pulse soft_rst_req_i=4'b1001 -> hart 0 is serviced fully, then hart 3, with no overlapping hold windows.
REQ-034 SHALL cover reset mid-operation: assert rst_i during HOLDRST of hart 3 -> all outputs are 0 at the next edge, the pending request is lost, and the reboot timing matches REQ-030.
